ysyx_22050854_divider: RTL and testbench

- Iterative radix-2 restoring divider for the RV64M divide family: div, divu, rem, remu, divw, divuw, remw, remuw.
- Counterpart to the Wallace-tree multiplier datapath; sits beside it in the EXU.
- Accepts one operation via a valid/ready handshake and returns quotient and remainder together after a fixed latency.
- Supports pipeline flush.

---
 rtl/ysyx_22050854_divider.sv | 136 +++++++++++++
 tb/tb_ysyx_22050854_divider.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_divider.sv
// Iterative radix-2 restoring divider for the RV64M divide family.
// Quotient and remainder come back together a fixed 65 cycles after the request is accepted.
module ysyx_22050854_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_divw, r_qNeg, r_rNeg, r_div0, r_ovf;
  logic [XLEN-1:0] r_quo, r_rem, r_dsr, r_dvdPrep;

  logic            w_accept, w_last, w_aNeg, w_bNeg, w_div0, w_ovf;
  logic [XLEN-1:0] w_aPrep, w_bPrep, w_aMag, w_bMag;
  logic [XLEN:0]   w_shift, w_trial;
  logic [XLEN-1:0] w_qNext, w_rNext, w_qRes, w_rRes, w_qOut, w_rOut;

  assign div_ready = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = (r_state == IDLE) && div_valid && !flush;
  assign w_last    = (r_state == CALC) && (r_cnt == CW'(XLEN - 1));

  // Word ops take the low half, sign- or zero-extended according to div_signed.
  always_comb begin
    w_aPrep = dividend;
    w_bPrep = divisor;
    if (divw) begin
      w_aPrep = {{HALF{div_signed & dividend[HALF-1]}}, dividend[HALF-1:0]};
      w_bPrep = {{HALF{div_signed & divisor[HALF-1]}}, divisor[HALF-1:0]};
    end
  end

  assign w_aNeg = div_signed & w_aPrep[XLEN-1];
  assign w_bNeg = div_signed & w_bPrep[XLEN-1];
  assign w_aMag = w_aNeg ? -w_aPrep : w_aPrep;
  assign w_bMag = w_bNeg ? -w_bPrep : w_bPrep;
  assign w_div0 = (w_bPrep == '0);
  assign w_ovf  = div_signed && (divw ?
                  (dividend[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}} && divisor[HALF-1:0] == {HALF{1'b1}}) :
                  (dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == {XLEN{1'b1}}));

  // One restoring step; the extra top bit of the trial is its borrow (trial < 0).
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dsr};
  assign w_qNext = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
  assign w_rNext = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];

  always_comb begin
    w_qRes = r_qNeg ? -w_qNext : w_qNext;
    w_rRes = r_rNeg ? -w_rNext : w_rNext;
    if (r_div0) begin
      w_qRes = '1;
      w_rRes = r_dvdPrep;
    end else if (r_ovf) begin
      w_qRes = r_dvdPrep;
      w_rRes = '0;
    end
    w_qOut = r_divw ? {{HALF{w_qRes[HALF-1]}}, w_qRes[HALF-1:0]} : w_qRes;
    w_rOut = r_divw ? {{HALF{w_rRes[HALF-1]}}, w_rRes[HALF-1:0]} : w_rRes;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_divw    <= 1'b0;
      r_qNeg    <= 1'b0;
      r_rNeg    <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dsr     <= '0;
      r_dvdPrep <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_divw    <= divw;
      r_qNeg    <= w_aNeg ^ w_bNeg;
      r_rNeg    <= w_aNeg;
      r_div0    <= w_div0;
      r_ovf     <= w_ovf;
      r_quo     <= w_aMag;
      r_rem     <= '0;
      r_dsr     <= w_bMag;
      r_dvdPrep <= w_aPrep;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_quo <= w_qNext;
      r_rem <= w_rNext;
    end
  end

  // Results are held until the next completed op; a flush on the final step drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (w_last && !flush) begin
      quotient  <= w_qOut;
      remainder <= w_rOut;
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_divider.sv
// Self-checking bench for ysyx_22050854_divider: scoreboard of expected results
// checked against every out_valid pulse, plus scenario tasks for latency, flush and reset.
module tb_ysyx_22050854_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        divw = 1'b0;
  logic        div_signed = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   cycleCnt = 0;

  ysyx_22050854_divider #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .div_valid(div_valid), .div_ready(div_ready),
    .divw(divw), .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Every out_valid pulse must match the oldest expected result and arrive 65 cycles after accept.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_out_valid at cycle %0d q=%h r=%h", cycleCnt, quotient, remainder);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        total++;
        if (quotient !== e.q) begin
          bad++;
          $display("[TB] FAIL quotient got=%h want=%h", quotient, e.q);
        end
        total++;
        if (remainder !== e.r) begin
          bad++;
          $display("[TB] FAIL remainder got=%h want=%h", remainder, e.r);
        end
        total++;
        if (cycleCnt !== e.cyc + 65) begin
          bad++;
          $display("[TB] FAIL latency got_cycle=%0d want_cycle=%0d", cycleCnt, e.cyc + 65);
        end
      end
    end
  end

  // Behavioural reference with the RISC-V corner cases handled explicitly.
  function automatic void refDiv(input logic w, input logic s, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 0;
      end else if (s) begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end else begin
        q = a / b; r = a % b;
      end
    end
  endfunction

  // Waits for div_ready, presents one request for one cycle, optionally pushes its expectation.
  task automatic applyStimulus(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] q, input logic [63:0] r, input bit push,
                               output int acc);
    int waitCnt = 0;
    acc = -1;
    while (!div_ready && waitCnt < 200) begin
      @(posedge clk); #1; waitCnt++;
    end
    if (!div_ready) begin
      total++; bad++;
      $display("[TB] FAIL ready_timeout got=%b want=1", div_ready);
      return;
    end
    div_valid = 1'b1; divw = w; div_signed = s; dividend = a; divisor = b;
    acc = cycleCnt;
    if (push) expQ.push_back('{q: q, r: r, cyc: acc});
    @(posedge clk); #1;
    div_valid = 1'b0;
    divw = $urandom_range(0, 1); div_signed = $urandom_range(0, 1);
    dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
  endtask

  task automatic drain();
    int waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 300) begin
      @(posedge clk); #1; waitCnt++;
    end
    if (expQ.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout pending=%0d want=0", expQ.size());
      expQ.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (quotient !== 64'h0 || remainder !== 64'h0 || out_valid !== 1'b0 || div_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_state got q=%h r=%h v=%b rdy=%b want 0/0/0/1", quotient, remainder, out_valid, div_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int acc;
    applyStimulus(0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 1, acc);
    total++;
    if (div_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL ready_busy_first got=%b want=0", div_ready);
    end
    repeat (64) begin @(posedge clk); #1; end
    total++;
    if (div_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL done_cycle got rdy=%b v=%b want rdy=0 v=1", div_ready, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (div_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL after_done got rdy=%b v=%b want rdy=1 v=0", div_ready, out_valid);
    end
    drain();
  endtask

  task automatic test_corners();
    int acc;
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1, acc);
    drain();
    applyStimulus(0, 1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, acc);
    drain();
    applyStimulus(1, 0, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, acc);
    drain();
    applyStimulus(0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0, 1, acc);
    drain();
    applyStimulus(1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h0, 1, acc);
    drain();
    applyStimulus(1, 0, 64'hDEAD_BEEF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 64'h0, 1, acc);
    drain();
  endtask

  task automatic test_random();
    int acc;
    logic [63:0] a, b, q, r;
    logic w, s;
    for (int i = 0; i < 12; i++) begin
      w = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 62);
      if (i == 3) b = 64'd1;
      refDiv(w, s, a, b, q, r);
      applyStimulus(w, s, a, b, q, r, 1, acc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    applyStimulus(0, 0, 64'd1000, 64'd33, 64'd30, 64'd10, 1, acc1);
    applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1, acc2);
    total++;
    if (acc2 - acc1 !== 66) begin
      bad++; $display("[TB] FAIL back_to_back_gap got=%0d want=66", acc2 - acc1);
    end
    drain();
  endtask

  task automatic test_flush();
    int acc;
    applyStimulus(0, 0, 64'd5000, 64'd3, 64'd0, 64'd0, 0, acc);
    while (cycleCnt < acc + 30) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (div_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL flush_ready got=%b want=1", div_ready);
    end
    div_valid = 1'b1; flush = 1'b1; dividend = 64'd50; divisor = 64'd5; divw = 1'b0; div_signed = 1'b0;
    @(posedge clk); #1;
    div_valid = 1'b0; flush = 1'b0;
    total++;
    if (div_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL flush_beats_valid got_ready=%b want=1", div_ready);
    end
    applyStimulus(0, 0, 64'd9, 64'd3, 64'd3, 64'd0, 1, acc);
    drain();
    repeat (70) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_mid();
    int acc;
    applyStimulus(0, 0, 64'd77, 64'd5, 64'd0, 64'd0, 0, acc);
    while (cycleCnt < acc + 40) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if (quotient !== 64'h0 || remainder !== 64'h0 || out_valid !== 1'b0 || div_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid got q=%h r=%h v=%b rdy=%b want 0/0/0/1", quotient, remainder, out_valid, div_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
